// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative multiply/divide unit for the EX stage.
//
// Runs MULT/MULTU as a radix-2 shift-add over 32 cycles. When the
// divider is built, DIV/DIVU run as a radix-2 restoring divide over
// 32 cycles. Holds the HI/LO registers. MTHI/MTLO write HI/LO in a
// single cycle. md_stall holds the front of the pipeline while an
// operation is accepted or in flight.
//
// Build option: define EX_MULDIV_DIV_EN to build the divider and the
// DIV state. Without it, DIV/DIVU act as no-ops and md_div_zero is 0.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   ex_rdata1    operand A (dividend / multiplicand / MTHI-MTLO source)
//   ex_rdata2    operand B (divisor / multiplier)
//   md_op        operation code (1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO)
//   md_stall     hold upstream and ID/EX while high
//   md_busy      iteration in progress
//   hi, lo       architectural HI/LO
//   md_div_zero  one-cycle pulse in DONE after a divide by zero
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | waiting for an op; MTHI/MTLO complete here
// MUL   | one multiplier bit per cycle, 32 cycles
// DIV   | one quotient bit per cycle, 32 cycles
// DONE  | results visible, stall low, md_op ignored

module ex_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] ex_rdata1,
    input  logic [WIDTH-1:0] ex_rdata2,
    input  logic [2:0]       md_op,
    output logic             md_stall,
    output logic             md_busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             md_div_zero
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd3
`ifdef EX_MULDIV_DIV_EN
        , S_DIV = 2'd2
`endif
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    // MUL: {partial product, remaining multiplier bits}
    // DIV: {partial remainder, dividend bits shifting into quotient}
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   opnd_q;     // multiplicand or divisor magnitude
    logic               neg_q;      // negate product / quotient at the end
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               div_zero_q;

    logic               op_mul;
    logic               op_div;
    logic               op_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_acc_d;
    logic [2*WIDTH-1:0] mul_res_d;

`ifdef EX_MULDIV_DIV_EN
    logic               neg_rem_q;  // remainder takes the dividend's sign
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     rem_diff;
    logic [2*WIDTH-1:0] div_acc_d;
    logic [WIDTH-1:0]   quot_res_d;
    logic [WIDTH-1:0]   rem_res_d;
`endif

    always_comb begin
        op_mul    = (md_op == OP_MULT) || (md_op == OP_MULTU);
`ifdef EX_MULDIV_DIV_EN
        op_div    = (md_op == OP_DIV) || (md_op == OP_DIVU);
`else
        op_div    = 1'b0;
`endif
        op_signed = (md_op == OP_MULT) || (md_op == OP_DIV);
        a_neg     = op_signed & ex_rdata1[WIDTH-1];
        b_neg     = op_signed & ex_rdata2[WIDTH-1];
        a_mag     = a_neg ? -ex_rdata1 : ex_rdata1;
        b_mag     = b_neg ? -ex_rdata2 : ex_rdata2;

        // Add the multiplicand into the upper half when the current
        // multiplier bit is set, then shift right keeping the carry.
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        mul_res_d = neg_q ? -mul_acc_d : mul_acc_d;

`ifdef EX_MULDIV_DIV_EN
        // Restoring step: the shifted remainder is below twice the
        // divisor, so a non-negative difference always fits WIDTH bits.
        rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, opnd_q};
        if (!rem_diff[WIDTH]) begin
            div_acc_d = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            div_acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
        quot_res_d = neg_q ? -div_acc_d[WIDTH-1:0] : div_acc_d[WIDTH-1:0];
        rem_res_d  = neg_rem_q ? -div_acc_d[2*WIDTH-1:WIDTH] : div_acc_d[2*WIDTH-1:WIDTH];
`endif

        md_busy = (state_q == S_MUL)
`ifdef EX_MULDIV_DIV_EN
                  || (state_q == S_DIV)
`endif
                  ;
        md_stall = md_busy || ((state_q == S_IDLE) && (op_mul || op_div));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            neg_q      <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
`ifdef EX_MULDIV_DIV_EN
            neg_rem_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    div_zero_q <= 1'b0;
                    cnt_q      <= '0;
                    if (op_mul) begin
                        opnd_q  <= a_mag;
                        acc_q   <= {{WIDTH{1'b0}}, b_mag};
                        neg_q   <= a_neg ^ b_neg;
                        state_q <= S_MUL;
`ifdef EX_MULDIV_DIV_EN
                    end else if (op_div) begin
                        if (ex_rdata2 == '0) begin
                            lo_q       <= '1;
                            hi_q       <= ex_rdata1;
                            div_zero_q <= 1'b1;
                            state_q    <= S_DONE;
                        end else begin
                            opnd_q    <= b_mag;
                            acc_q     <= {{WIDTH{1'b0}}, a_mag};
                            neg_q     <= a_neg ^ b_neg;
                            neg_rem_q <= a_neg;
                            state_q   <= S_DIV;
                        end
`endif
                    end else if (md_op == OP_MTHI) begin
                        hi_q <= ex_rdata1;
                    end else if (md_op == OP_MTLO) begin
                        lo_q <= ex_rdata1;
                    end
                end
                S_MUL: begin
                    acc_q <= mul_acc_d;
                    cnt_q <= cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        hi_q    <= mul_res_d[2*WIDTH-1:WIDTH];
                        lo_q    <= mul_res_d[WIDTH-1:0];
                        state_q <= S_DONE;
                    end
                end
`ifdef EX_MULDIV_DIV_EN
                S_DIV: begin
                    acc_q <= div_acc_d;
                    cnt_q <= cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        hi_q    <= rem_res_d;
                        lo_q    <= quot_res_d;
                        state_q <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    div_zero_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;
`ifdef EX_MULDIV_DIV_EN
    assign md_div_zero = div_zero_q;
`else
    // Only a divide can raise the flag, so it never sets in this build.
    assign md_div_zero = 1'b0 & div_zero_q;
`endif

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative multiply/divide unit in the EX stage. It consumes the operand pair registered by the ID/EX pipeline register and executes MULT, MULTU, DIV and DIVU over multiple cycles. It holds the architectural HI/LO registers and stalls the front of the pipeline while an operation is in flight. MTHI/MTLO writes also complete here, in a single cycle.

## Interface
Parameters:
- `WIDTH`, 32, operand and HI/LO width. Only 32 is supported.
- `CNT_W`, 5, iteration counter width; must satisfy 2^CNT_W = WIDTH.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ex_rdata1` in 32: operand A, the dividend or multiplicand; also the MTHI/MTLO source.
- `ex_rdata2` in 32: operand B, the divisor or multiplier.
- `md_op` in 3: operation code.
  - 000 none
  - 001 MULT
  - 010 MULTU
  - 011 DIV
  - 100 DIVU
  - 101 MTHI
  - 110 MTLO
  - 111 none
- `md_stall` out 1: upstream and ID/EX must hold while this is high.
- `md_busy` out 1: high in the MUL and DIV states.
- `hi` out 32: HI register.
- `lo` out 32: LO register.
- `md_div_zero` out 1: one-cycle pulse, in DONE, when a divide had divisor 0.

## Operation
- **States:** IDLE, MUL, DIV, DONE. Reset state is IDLE.
- **IDLE, op 001–100:**
  - Latch operands. For signed ops, latch magnitudes plus the result-sign flags (product sign = sign A xor sign B; quotient the same; remainder sign = sign A).
  - Clear the counter.
  - Go to MUL or DIV.
  - `md_stall` is driven high combinationally in this same cycle.
- **IDLE, DIV/DIVU with `ex_rdata2` == 0:** go directly to DONE. Results: LO = 0xFFFFFFFF, HI = `ex_rdata1` (raw). `md_div_zero` is set for DONE.
- **IDLE, 101/110:** HI or LO ← `ex_rdata1` at the edge. No stall. Stay in IDLE.
- **MUL:** radix-2 shift-add on a 64-bit accumulator, one multiplier bit per cycle, 32 iterations.
- **DIV:** radix-2 restoring division, one quotient bit per cycle, 32 iterations.
- **Last iteration (counter = 31):**
  - Apply the sign correction (two's complement of product / quotient / remainder as flagged).
  - Write HI/LO. MUL: HI = product[63:32], LO = product[31:0]. DIV: LO = quotient, HI = remainder.
  - Go to DONE.
- **DONE:**
  - `md_stall` is low, so the held instruction retires this cycle.
  - `md_op` is ignored, so the held op does not restart.
  - Return to IDLE.
- **Unsigned ops:** no sign handling. Signed overflow case 0x80000000 / −1 yields LO = 0x80000000, HI = 0.
- **Reset mid-operation:** abandon the operation. Go to IDLE; HI = LO = 0; all outputs at reset values.

## Timing
- Reset values:
  - `md_stall` = 0, `md_busy` = 0, `md_div_zero` = 0.
  - `hi` = 0x00000000, `lo` = 0x00000000.
- **Multi-cycle op accepted in cycle T:**
  - `md_stall` high in cycles T through T+32 (33 cycles).
  - `md_busy` high in T+1 through T+32.
  - New HI/LO visible from T+33, which is DONE with `md_stall` low.
- **Divide by zero accepted in cycle T:** `md_stall` high in T only. DONE is T+1, with `md_div_zero` = 1 and new HI/LO visible.
- **MTHI/MTLO in cycle T:** new value visible from T+1.
- **Back-to-back ops:** the next `md_op` is sampled in the first IDLE cycle after DONE. There is no bubble requirement beyond DONE.
- **Stall generation:** combinational from state and `md_op`; no registered lag.

## Configuration
- **`EX_MULDIV_DIV_EN` defined:** divider datapath and the DIV state are built, as described above.
- **`EX_MULDIV_DIV_EN` undefined:**
  - Ops 011/100 are treated as 000: no stall, HI/LO unchanged.
  - `md_div_zero` is tied to 0.
  - The DIV state is not built.
  - MUL behaviour is unchanged.

## Test plan
- **Signed multiply:** MULT A = 0xFFFFFFFE, B = 3 → `md_stall` high exactly 33 cycles; then HI = 0xFFFFFFFF, LO = 0xFFFFFFFA.
- **Unsigned multiply:** MULTU A = 0xFFFFFFFF, B = 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001 at T+33.
- **Signed divide:** DIV A = 0xFFFFFFF9 (−7), B = 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF; `md_div_zero` stays 0.
- **Divide by zero:** DIVU A = 0x12345678, B = 0 → `md_stall` high 1 cycle; next cycle `md_div_zero` = 1, LO = 0xFFFFFFFF, HI = 0x12345678.
- **Reset mid-operation:** `rst` asserted during iteration 10 of a MULT → next cycle `md_stall` = 0, `md_busy` = 0, HI = LO = 0; a following MTLO of 0xA5A5A5A5 sets LO = 0xA5A5A5A5 one cycle later.
- **No restart from DONE:** `md_op` held at MULT through DONE → exactly one operation executes, and IDLE is re-entered with no second stall.
